fns_decoder_2_7: RTL and testbench

- Receive-side decoder for the 9-TSV Fibonacci-numeral-system (FNS) CAC link. It sits directly downstream of the 9-bit FNS coder and the TSV bundle.
- Reconstructs the data word as the weighted sum of enabled code bits. Disabled (faulty or redundant) TSV positions, marked by the same en_flag the coder used, contribute nothing.
- Three-stage valid/ready pipeline. Weights are programmable so the local adaptive FNS assignment can change at run time.

---
 rtl/fns_decoder_2_7_pkg.sv | 15 +
 rtl/fns_decoder_2_7_if.sv | 30 +++
 rtl/fns_decoder_2_7_partial_sum.sv | 28 ++
 rtl/fns_decoder_2_7.sv | 108 ++++++++++
 tb/tb_fns_decoder_2_7.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fns_decoder_2_7_pkg.sv
// Shared FNS definitions for the 9-TSV Fibonacci-numeral-system CAC link:
// code/weight widths, the largest legal data value and the default weight set.
package fns_decoder_2_7_pkg;

   localparam int FNS_CODE_W   = 9;               // TSV code bits (x+y)
   localparam int FNS_W_W      = 7;               // width of one weight and of the data word
   localparam int FNS_DATA_MAX = 88;              // largest legal decoded value
   localparam int FNS_LO_N     = 4;               // code bits summed by the low partial adder

   // Default Fibonacci weights, bit8 down to bit0: 34,21,13,8,5,3,2,1,1.
   localparam logic [FNS_CODE_W*FNS_W_W-1:0] FNS_DEF_WEIGHTS = {
      7'd34, 7'd21, 7'd13, 7'd8, 7'd5, 7'd3, 7'd2, 7'd1, 7'd1
   };

endpackage

// File: rtl/fns_decoder_2_7_if.sv
// Code-in / data-out stream of the FNS decoder.
// Valid/ready: a word moves when valid and ready are both 1 at a rising clock
// edge; the sender keeps valid and the payload steady until that edge, and
// valid never depends on ready.
interface fns_decoder_2_7_if
   import fns_decoder_2_7_pkg::*;
#(
   parameter int CODE_W = FNS_CODE_W,
   parameter int W_W    = FNS_W_W
);
   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] codein;
   logic              out_valid;
   logic              out_ready;
   logic [W_W-1:0]    dataout;
   logic              err;

   // Upstream source and downstream sink seen together as one agent.
   modport master (
      output in_valid, codein, out_ready,
      input  in_ready, out_valid, dataout, err
   );

   // The decoder side.
   modport slave (
      input  in_valid, codein, out_ready,
      output in_ready, out_valid, dataout, err
   );
endinterface

// File: rtl/fns_decoder_2_7_partial_sum.sv
// Combinational weighted sum of a slice of masked code bits. The sum is kept
// SUM_W bits wide; ovf flags any carry lost above that width.
module fns_decoder_2_7_partial_sum #(
   parameter int N     = 4,
   parameter int W_W   = 7,
   parameter int SUM_W = 9
) (
   input  logic [N-1:0]     bits,
   input  logic [N*W_W-1:0] weights,
   output logic [SUM_W-1:0] sum,
   output logic             ovf
);
   // Four spare bits hold any carry of up to 16 weights.
   localparam int ACC_W = SUM_W + 4;

   logic [ACC_W-1:0] acc;

   // Add the weight of every set bit.
   always_comb begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
         if (bits[i]) acc = acc + ACC_W'(weights[i*W_W +: W_W]);
      end
   end

   assign sum = acc[SUM_W-1:0];
   assign ovf = |acc[ACC_W-1:SUM_W];
endmodule

// File: rtl/fns_decoder_2_7.sv
// FNS receive-side decoder: three-stage valid/ready pipeline that rebuilds the
// data word as the weighted sum of enabled code bits.
//   S1: masked code   S2: two partial sums   S3: final sum, range check
// Stages advance together unless the output is stalled; holes are kept.
module fns_decoder_2_7
   import fns_decoder_2_7_pkg::*;
#(
   parameter int CODE_W   = FNS_CODE_W,
   parameter int W_W      = FNS_W_W,
   parameter int DATA_MAX = FNS_DATA_MAX
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cfg_load,
   input  logic [CODE_W*W_W-1:0] fns_weights,
   input  logic [CODE_W-1:0]     en_flag,
   output logic                  busy,
   fns_decoder_2_7_if.slave      bus
);
   localparam int LO_N   = FNS_LO_N;
   localparam int HI_N   = CODE_W - LO_N;
   localparam int PART_W = W_W + 2;
   localparam int SUM_W  = W_W + 3;

   logic                  rdy_en;
   logic [CODE_W*W_W-1:0] w_cfg;
   logic [CODE_W-1:0]     en_cfg;
   logic                  v1, v2, v3;
   logic [CODE_W-1:0]     m1;
   logic [PART_W-1:0]     ps_lo, ps_hi, ps_lo2, ps_hi2;
   logic                  ovf_lo, ovf_hi, ovf2;
   logic [SUM_W-1:0]      sum_full;
   logic [W_W-1:0]        data_q;
   logic                  err_q;
   logic                  stall, accept;

   assign stall         = v3 & ~bus.out_ready;
   assign bus.in_ready  = rdy_en & ~stall & ~cfg_load;
   assign accept        = bus.in_valid & bus.in_ready;
   assign busy          = v1 | v2 | v3;
   assign bus.out_valid = v3;
   assign bus.dataout   = data_q;
   assign bus.err       = err_q;

   // Input side opens on the first clock after reset release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rdy_en <= 1'b0;
      else       rdy_en <= 1'b1;
   end

   // Config capture only while the pipeline is empty, so in-flight words
   // never see a weight change.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         w_cfg  <= '0;
         en_cfg <= '0;
      end else if (cfg_load && !busy) begin
         w_cfg  <= fns_weights;
         en_cfg <= en_flag;
      end
   end

   fns_decoder_2_7_partial_sum #(.N(LO_N), .W_W(W_W), .SUM_W(PART_W)) u_sum_lo (
      .bits    (m1[LO_N-1:0]),
      .weights (w_cfg[LO_N*W_W-1:0]),
      .sum     (ps_lo),
      .ovf     (ovf_lo)
   );

   fns_decoder_2_7_partial_sum #(.N(HI_N), .W_W(W_W), .SUM_W(PART_W)) u_sum_hi (
      .bits    (m1[CODE_W-1:LO_N]),
      .weights (w_cfg[CODE_W*W_W-1:LO_N*W_W]),
      .sum     (ps_hi),
      .ovf     (ovf_hi)
   );

   // Two PART_W operands cannot overflow SUM_W.
   assign sum_full = SUM_W'(ps_lo2) + SUM_W'(ps_hi2);

   // Pipeline registers: everything holds while the output is stalled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         v3     <= 1'b0;
         m1     <= '0;
         ps_lo2 <= '0;
         ps_hi2 <= '0;
         ovf2   <= 1'b0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else if (!stall) begin
         v1 <= accept;
         v2 <= v1;
         v3 <= v2;
         if (accept) m1 <= bus.codein & en_cfg;
         if (v1) begin
            ps_lo2 <= ps_lo;
            ps_hi2 <= ps_hi;
            ovf2   <= ovf_lo | ovf_hi;
         end
         if (v2) begin
            data_q <= sum_full[W_W-1:0];
            err_q  <= ovf2 | (sum_full > SUM_W'(DATA_MAX));
         end
      end
   end
endmodule

// File: tb/tb_fns_decoder_2_7.sv
// Directed bench for the FNS decoder: reset, decode values, masking, range
// limits, back-to-back flow, backpressure and reset while words are in flight.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fns_decoder_2_7;
   import fns_decoder_2_7_pkg::*;

   logic                             clock = 1'b0;
   logic                             reset;
   logic                             cfg_load;
   logic [FNS_CODE_W*FNS_W_W-1:0]    fns_weights;
   logic [FNS_CODE_W-1:0]            en_flag;
   logic                             busy;
   int                               checks = 0;
   int                               errors = 0;

   fns_decoder_2_7_if bus ();

   fns_decoder_2_7 dut (
      .clock       (clock),
      .reset       (reset),
      .cfg_load    (cfg_load),
      .fns_weights (fns_weights),
      .en_flag     (en_flag),
      .busy        (busy),
      .bus         (bus)
   );

   // Clock and watchdog.
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end by itself");
      $fatal(1);
   end

   task automatic tick;
      @(negedge clock);
   endtask

   // Driver: one config load, leaves cfg_load low on a falling edge.
   task automatic load_cfg(input logic [FNS_CODE_W*FNS_W_W-1:0] w, input logic [FNS_CODE_W-1:0] en);
      tick;
      cfg_load    = 1'b1;
      fns_weights = w;
      en_flag     = en;
      tick;
      cfg_load    = 1'b0;
   endtask

   // Driver: push one word with out_ready=1; report out_valid two falling
   // edges after the drive (too early) and the output three edges after.
   task automatic run_word(input logic [FNS_CODE_W-1:0] code, output logic early_v,
                           output logic v, output logic [FNS_W_W-1:0] d, output logic e);
      tick;
      bus.in_valid = 1'b1;
      bus.codein   = code;
      tick;
      bus.in_valid = 1'b0;
      tick;
      early_v = bus.out_valid;
      tick;
      v = bus.out_valid;
      d = bus.dataout;
      e = bus.err;
   endtask

   task automatic test_reset;
      reset        = 1'b1;
      cfg_load     = 1'b0;
      fns_weights  = '0;
      en_flag      = '0;
      bus.in_valid = 1'b0;
      bus.codein   = '0;
      bus.out_ready = 1'b1;
      #12;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.dataout !== 7'd0) begin errors++; $display("FAIL reset_dataout: got %0d expected 0", bus.dataout); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
      tick;
      reset = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready: got %b expected 0", bus.in_ready); end
      tick;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL first_clock_in_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_basic;
      logic ev, v, e;
      logic [FNS_W_W-1:0] d;
      tick;
      cfg_load    = 1'b1;
      fns_weights = FNS_DEF_WEIGHTS;
      en_flag     = 9'h1FF;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL cfg_in_ready: got %b expected 0", bus.in_ready); end
      tick;
      cfg_load = 1'b0;
      // bit8 (34) + bit0 (1)
      run_word(9'b100000001, ev, v, d, e);
      checks++; if (ev !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", ev); end
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", v); end
      checks++; if (d !== 7'd35) begin errors++; $display("FAIL basic_data: got %0d expected 35", d); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", e); end
   endtask

   task automatic test_back_to_back;
      logic [FNS_CODE_W-1:0] codes [3];
      logic [FNS_W_W-1:0]    exp_d [3];
      codes[0] = 9'h000; exp_d[0] = 7'd0;
      codes[1] = 9'h002; exp_d[1] = 7'd1;   // bit1 weight 1
      codes[2] = 9'h155; exp_d[2] = 7'd55;  // bits 0,2,4,6,8: 1+2+5+13+34
      for (int i = 0; i < 3; i++) begin
         tick;
         bus.in_valid = 1'b1;
         bus.codein   = codes[i];
         #1;
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      end
      tick;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick;
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.out_valid); end
         checks++; if (bus.dataout !== exp_d[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, bus.dataout, exp_d[i]); end
      end
      tick;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_mask;
      logic ev, v, e;
      logic [FNS_W_W-1:0] d;
      load_cfg(FNS_DEF_WEIGHTS, 9'b111101111);
      // bit4 (5) masked, bit0 (1) left
      run_word(9'b000010001, ev, v, d, e);
      checks++; if (v !== 1'b1 || d !== 7'd1) begin errors++; $display("FAIL mask_data: got v=%b %0d expected v=1 1", v, d); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL mask_err: got %b expected 0", e); end
   endtask

   task automatic test_boundary;
      logic ev, v, e;
      logic [FNS_W_W-1:0] d;
      logic [FNS_CODE_W*FNS_W_W-1:0] w_alt;
      load_cfg(FNS_DEF_WEIGHTS, 9'h1FF);
      run_word(9'h1FF, ev, v, d, e);   // sum of all default weights = 88
      checks++; if (v !== 1'b1 || d !== 7'd88) begin errors++; $display("FAIL max_data: got v=%b %0d expected v=1 88", v, d); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL max_err: got %b expected 0", e); end
      w_alt = FNS_DEF_WEIGHTS;
      w_alt[62:56] = 7'd40;            // 88 - 34 + 40 = 94
      load_cfg(w_alt, 9'h1FF);
      run_word(9'h1FF, ev, v, d, e);
      checks++; if (d !== 7'd94) begin errors++; $display("FAIL over_data: got %0d expected 94", d); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL over_err: got %b expected 1", e); end
      load_cfg({9{7'd127}}, 9'h1FF);   // high slice 5*127 = 635 overflows 9 bits
      run_word(9'h1FF, ev, v, d, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL adder_ovf_err: got %b expected 1", e); end
      load_cfg(FNS_DEF_WEIGHTS, 9'h000);
      run_word(9'h1FF, ev, v, d, e);
      checks++; if (v !== 1'b1 || d !== 7'd0 || e !== 1'b0) begin errors++; $display("FAIL all_masked: got v=%b %0d err=%b expected v=1 0 err=0", v, d, e); end
   endtask

   task automatic test_backpressure;
      logic [FNS_CODE_W-1:0] codes [3];
      logic [FNS_W_W-1:0]    exp_d [3];
      codes[0] = 9'h001; exp_d[0] = 7'd1;
      codes[1] = 9'h100; exp_d[1] = 7'd34;
      codes[2] = 9'h0A0; exp_d[2] = 7'd29;  // bits 5,7: 8+21
      load_cfg(FNS_DEF_WEIGHTS, 9'h1FF);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         bus.in_valid = 1'b1;
         bus.codein   = codes[i];
         #1;
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      end
      for (int c = 0; c < 4; c++) begin
         tick;
         bus.in_valid = 1'b0;
         checks++; if (bus.out_valid !== 1'b1 || bus.dataout !== exp_d[0]) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %0d expected v=1 %0d", c, bus.out_valid, bus.dataout, exp_d[0]); end
         checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_stall[%0d]: got in_ready=%b busy=%b expected 0 1", c, bus.in_ready, busy); end
      end
      tick;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick;
         #1;
         checks++; if (bus.out_valid !== 1'b1 || bus.dataout !== exp_d[i]) begin errors++; $display("FAIL bp_drain[%0d]: got v=%b %0d expected v=1 %0d", i, bus.out_valid, bus.dataout, exp_d[i]); end
      end
      tick;
      checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_empty: got v=%b busy=%b expected 0 0", bus.out_valid, busy); end
   endtask

   task automatic test_reset_midstream;
      int   seen;
      logic ev, v, e;
      logic [FNS_W_W-1:0] d;
      tick;
      bus.in_valid = 1'b1;
      bus.codein   = 9'h001;
      tick;
      bus.codein   = 9'h100;
      tick;
      bus.in_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
      reset = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset: got v=%b busy=%b expected 0 0", bus.out_valid, busy); end
      tick;
      tick;
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         tick;
         if (bus.out_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL mid_discard: got %0d outputs expected 0", seen); end
      // cfg_load while a word is in flight must be ignored.
      tick;
      bus.in_valid = 1'b1;
      bus.codein   = 9'h001;
      tick;
      bus.in_valid = 1'b0;
      cfg_load     = 1'b1;
      fns_weights  = FNS_DEF_WEIGHTS;
      en_flag      = 9'h1FF;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_cfg_precond: got %b expected 1", busy); end
      tick;
      cfg_load = 1'b0;
      tick;
      checks++; if (bus.out_valid !== 1'b1 || bus.dataout !== 7'd0) begin errors++; $display("FAIL zero_cfg_data: got v=%b %0d expected v=1 0", bus.out_valid, bus.dataout); end
      run_word(9'h001, ev, v, d, e);
      checks++; if (v !== 1'b1 || d !== 7'd0) begin errors++; $display("FAIL busy_cfg_ignored: got v=%b %0d expected v=1 0", v, d); end
      load_cfg(FNS_DEF_WEIGHTS, 9'h1FF);
      run_word(9'h001, ev, v, d, e);
      checks++; if (v !== 1'b1 || d !== 7'd1) begin errors++; $display("FAIL idle_cfg_captured: got v=%b %0d expected v=1 1", v, d); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_mask;
      test_boundary;
      test_backpressure;
      test_reset_midstream;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
